count_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit free-running/loadable counter value.
- Snapshots the counter output and serialises it as a UART 8N1 frame on a single output pin, so the count can be read by an external host.
- Supports explicit capture strobes, or automatic capture whenever the count changes.
- Drops requests that arrive while a frame is in flight and flags the drop.

---
 rtl/count_uart_pkg.sv | 20 ++
 rtl/count_uart_tx_baud_tick_gen.sv | 41 ++++
 rtl/count_uart_tx.sv | 135 +++++++++++++
 tb/tb_count_uart_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-value UART transmitter.
package count_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;
   localparam int BAUD_CNT_W = 16;

   // Terminal value of the baud counter for a given bit period.
   function automatic logic [BAUD_CNT_W-1:0] baud_last(input int unsigned clks);
      return BAUD_CNT_W'(clks - 32'd1);
   endfunction

endpackage

// File: rtl/count_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module baud_tick_gen
   import count_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [BAUD_CNT_W-1:0] LAST = baud_last(CLKS_PER_BIT);

   logic [BAUD_CNT_W-1:0] cnt_q;
   logic [BAUD_CNT_W-1:0] cnt_d;

   // Next count: held at zero while cleared, wraps at each bit boundary.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {BAUD_CNT_W{1'b0}};
      end else if (cnt_q == LAST) begin
         cnt_d = {BAUD_CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + {{(BAUD_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {BAUD_CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/count_uart_tx.sv
// Snapshots an 8-bit count and sends it as a UART 8N1 frame, LSB first.
module count_uart_tx
   import count_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          AUTO_CAPTURE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count_in,
   input  logic       capture,
   output logic       tx,
   output logic       busy,
   output logic       dropped
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] last_count_q;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       dropped_q, dropped_d;
   logic       req;
   logic       baud_tick;
   logic       baud_clear;

   assign req        = AUTO_CAPTURE ? (count_in != last_count_q) : capture;
   assign baud_clear = (state_q == IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (baud_tick)
   );

   // Frame sequencing; tx and busy are computed one cycle ahead of their flops.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      dropped_d = dropped_q;

      // Any request outside IDLE, including the last stop-bit cycle, is lost.
      if (req && (state_q != IDLE)) begin
         dropped_d = 1'b1;
      end else begin
         dropped_d = dropped_q;
      end

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = START;
               shift_d = count_in;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end else begin
               tx_d   = 1'b1;
               busy_d = 1'b0;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
            end else begin
               tx_d = 1'b0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end else begin
               tx_d = shift_q[0];
            end
         end
         STOP: begin
            if (baud_tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               tx_d    = 1'b1;
            end else begin
               tx_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; last_count tracks count_in even during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= 8'h00;
         bit_idx_q    <= 3'd0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         dropped_q    <= 1'b0;
         last_count_q <= count_in;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         dropped_q    <= dropped_d;
         last_count_q <= count_in;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: explicit-capture and auto-capture instances share one clock.
module tb_count_uart_tx;

   localparam int C = 4;

   logic       clk;
   logic       rst;
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic       cap0;
   logic       cap1;
   logic       tx0, busy0, drop0;
   logic       tx1, busy1, drop1;
   logic       sel;
   logic       tx_m, busy_m;

   logic [7:0] sb[$];
   int         n_assert;
   int         n_fail;

   count_uart_tx #(.CLKS_PER_BIT(C), .AUTO_CAPTURE(1'b0)) dut (
      .clk(clk), .rst(rst), .count_in(cnt0), .capture(cap0),
      .tx(tx0), .busy(busy0), .dropped(drop0)
   );

   count_uart_tx #(.CLKS_PER_BIT(C), .AUTO_CAPTURE(1'b1)) dut_auto (
      .clk(clk), .rst(rst), .count_in(cnt1), .capture(cap1),
      .tx(tx1), .busy(busy1), .dropped(drop1)
   );

   assign tx_m   = sel ? tx1 : tx0;
   assign busy_m = sel ? busy1 : busy0;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request for value v (capture strobe or count change) and take the accept edge.
   task automatic start(input logic [7:0] v);
      if (sel) begin
         cnt1 = v;
      end else begin
         cnt0 = v;
         cap0 = 1'b1;
      end
      sb.push_back(v);
      tick();
      cap0 = 1'b0;
   endtask

   // Called just after the accept edge; walks the whole frame and scores it.
   task automatic run_frame(input string tag, input int cap_at, input int chg_at,
                            input logic [7:0] chg_val);
      logic [7:0] exp_b;
      logic [7:0] got;
      logic [7:0] popped;
      logic       e;
      int         bad;
      int         busyc;
      int         bitn;
      exp_b = (sb.size() > 0) ? sb[0] : 8'h00;
      got   = 8'h00;
      bad   = 0;
      busyc = 0;
      for (int k = 0; k < 10 * C; k++) begin
         bitn = k / C;
         if (bitn == 0)      e = 1'b0;
         else if (bitn == 9) e = 1'b1;
         else                e = exp_b[bitn-1];
         if (tx_m !== e) bad++;
         if (busy_m === 1'b1) busyc++;
         if (bitn >= 1 && bitn <= 8 && (k % C) == C / 2) got[bitn-1] = tx_m;
         cap0 = (k == cap_at) ? 1'b1 : 1'b0;
         if (k == chg_at) begin
            if (sel) cnt1 = chg_val;
            else     cnt0 = chg_val;
         end
         tick();
      end
      cap0 = 1'b0;
      popped = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk({tag, "_txpattern_errs"}, bad, 0);
      chk({tag, "_busy_cycles"}, busyc, 10 * C);
      chk({tag, "_data"}, {24'h0, got}, {24'h0, popped});
      chk({tag, "_busy_end"}, {31'h0, busy_m}, 32'h0);
      chk({tag, "_tx_end"}, {31'h0, tx_m}, 32'h1);
   endtask

   initial begin
      int cnt_a;
      int cnt_b;
      n_assert = 0;
      n_fail   = 0;
      clk  = 1'b0;
      rst  = 1'b1;
      cnt0 = 8'h5A;
      cnt1 = 8'h5A;
      cap0 = 1'b0;
      cap1 = 1'b0;
      sel  = 1'b0;

      // reset values on both instances
      repeat (3) tick();
      chk("rst_tx0", {31'h0, tx0}, 32'h1);
      chk("rst_busy0", {31'h0, busy0}, 32'h0);
      chk("rst_drop0", {31'h0, drop0}, 32'h0);
      chk("rst_tx1", {31'h0, tx1}, 32'h1);
      chk("rst_busy1", {31'h0, busy1}, 32'h0);
      chk("rst_drop1", {31'h0, drop1}, 32'h0);
      rst = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy0 !== 1'b0) cnt_a++;
         if (busy1 !== 1'b0 || tx1 !== 1'b1) cnt_b++;
      end
      chk("idle_after_rst0", cnt_a, 0);
      chk("idle_after_rst_auto", cnt_b, 0);

      // single frame 0xA5
      start(8'hA5);
      run_frame("a5", -1, -1, 8'h00);

      // snapshot frozen at accept
      tick();
      start(8'h01);
      run_frame("freeze", -1, 0, 8'hFF);

      // request while busy is dropped and the flag is sticky
      tick();
      start(8'h3C);
      run_frame("drop", 10, -1, 8'h00);
      chk("drop_set", {31'h0, drop0}, 32'h1);
      repeat (5) tick();
      chk("drop_sticky", {31'h0, drop0}, 32'h1);
      chk("drop_no_frame", {31'h0, busy0}, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("drop_cleared", {31'h0, drop0}, 32'h0);
      tick();

      // capture on last stop cycle is dropped, one cycle later is accepted
      start(8'hC3);
      run_frame("stopcap", 10 * C - 1, -1, 8'h00);
      chk("stopcap_drop", {31'h0, drop0}, 32'h1);
      start(8'h5E);
      run_frame("b2b", -1, -1, 8'h00);

      // reset during data bit 3 aborts, then a clean frame follows
      tick();
      start(8'hE7);
      repeat (4 * C + 1) tick();
      rst = 1'b1;
      tick();
      chk("abort_tx", {31'h0, tx0}, 32'h1);
      chk("abort_busy", {31'h0, busy0}, 32'h0);
      void'(sb.pop_front());
      rst = 1'b0;
      tick();
      start(8'h96);
      run_frame("post_abort", -1, -1, 8'h00);

      // auto capture: one step produces exactly one frame
      sel  = 1'b1;
      rst  = 1'b1;
      cnt1 = 8'h00;
      tick();
      rst = 1'b0;
      tick();
      start(8'h01);
      run_frame("auto", -1, -1, 8'h00);
      cnt_a = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (busy1 !== 1'b0 || tx1 !== 1'b1) cnt_a++;
      end
      chk("auto_no_more_frames", cnt_a, 0);
      chk("auto_drop", {31'h0, drop1}, 32'h0);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
